lights_phase_scheduler: RTL
===========================

# lights_phase_scheduler

Phase scheduler for the intersection: latches service requests from the three traffic approaches (left, middle, right) and the pedestrian crossing, grants the shared crossing to one requester at a time in round-robin order, and sequences each grant through green, yellow and all-red clearance. It drives the one-hot grant to the light drivers and a seconds-remaining count for the seven-segment display path. It uses one clock domain and contains its own 1 s prescaler.

## Interface
- ClockPeriod_ns, 20: clock period; documentation only, TickCycles must be consistent with it.
- TickCycles, 50_000_000: clock cycles per 1 s tick; reduced in simulation.
- Green_s, 20: green duration in ticks, range 1..255.
- Yellow_s, 3: yellow duration in ticks, range 1..255.
- AllRed_s, 2: all-red clearance in ticks, range 1..255.
- Clock  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  4  request per requester, [0]=TL [1]=TM [2]=TR [3]=pedestrian; sampled every cycle, a one-cycle pulse is sufficient.
- Grant  output  4  one-hot green grant, or all zero.
- Yellow  output  1  granted requester is in yellow; Grant still holds its index.
- AllRed  output  1  clearance phase or idle.
- SecLeft  output  8  ticks remaining in the current phase; 0 in IDLE.
- Busy  output  1  not in IDLE.
- Beep  output  1  buzzer, active-low; idle level 1.

## Operation
- States: IDLE, GREEN, YELLOW, CLEAR.
- Pending[3:0] register: bit i is set by Req[i]=1.
  - Pending[i] is cleared in the cycle the FSM enters GREEN for i.
  - Req[i] during GREEN or YELLOW of i is dropped.
  - Req[i] during CLEAR after i is latched.
- Round-robin: Ptr holds the last granted index. The search starts at Ptr+1 and wraps 3→0. Reset sets Ptr=3, so TL has first priority.
- IDLE: Grant=0, AllRed=1. If any Pending bit is set, go to GREEN for the round-robin winner on the next cycle (no clearance).
- GREEN: lasts Green_s ticks. At expiry:
  - if any other Pending bit is set, go to YELLOW;
  - otherwise reload Green_s and stay in GREEN (rest in green, same Grant).
- YELLOW: lasts Yellow_s ticks, then go to CLEAR.
- CLEAR: lasts AllRed_s ticks with Grant=0. At expiry go to GREEN for the winner, or to IDLE if Pending=0.
- Pedestrian (index 3) YELLOW means flashing don't-walk. The light driver decodes it; this block only flags it.
- Arithmetic: SecLeft is an 8-bit unsigned down-counter. The prescaler counter is clog2(TickCycles) bits wide and wraps at TickCycles-1.

## Timing
- Reset values: Grant=0, Yellow=0, AllRed=1, SecLeft=0, Busy=0, Beep=1, Pending=0, Ptr=3, state IDLE, prescaler 0.
- Req latency:
  - Req[i] in cycle n reaches Pending in cycle n+1.
  - From IDLE, Grant[i] and Busy rise in cycle n+2.
- Phase entry: SecLeft loads the phase duration and the prescaler clears to 0 on the same edge.
- Ticks: a tick fires when the prescaler equals TickCycles-1. SecLeft decrements on each tick.
- Phase exit: the phase ends on the tick where SecLeft=1. New outputs appear the next cycle, so each phase lasts exactly duration×TickCycles cycles.
- Simultaneous events: a requester set in Pending in the same cycle as a green expiry counts for that expiry decision.
- Reset mid-phase returns all state to reset values on the next edge. Pending requests are lost.
- Outputs are registered; no combinational path from Req to outputs.

## Configuration
- PED_BEEP_EN defined:
  - during GREEN for index 3, Beep toggles on every tick, starting at 0 on GREEN entry;
  - Beep returns to 1 on leaving GREEN.
- PED_BEEP_EN undefined: Beep is constant 1, and the toggle logic is not compiled.

## Test plan
All scenarios use TickCycles=4, Green_s=3, Yellow_s=2, AllRed_s=1.
- Reset then idle:
  - stimulus: no Req for 100 cycles;
  - required: Grant=0, AllRed=1, SecLeft=0, Busy=0, Beep=1 throughout.
- Single request:
  - stimulus: one-cycle pulse Req=0001 at cycle n;
  - required: Grant=0001 at n+2 with SecLeft=3;
  - with no other Pending, Grant stays 0001 and SecLeft cycles 3,2,1,3 with no yellow.
- Round-robin:
  - stimulus: Req=1111 pulse, then none;
  - required: grant order 0001, 0010, 0100, 1000, then rest in green on 1000;
  - each handover shows Yellow=1 for 8 cycles, then AllRed=1, Grant=0 for 4 cycles.
- Drop self-request:
  - stimulus: Req[1] pulses while Grant=0010 and Req[2] is pending;
  - required: after the CLEAR that follows 0100, the FSM goes to IDLE, not back to 0010.
- Reset mid-YELLOW:
  - stimulus: Reset=1 for one cycle while Yellow=1;
  - required: reset values on the next cycle; the next Req=0100 pulse is granted 0100 from IDLE.
- PED_BEEP_EN defined:
  - stimulus: Req=1000;
  - required: Beep=0 at green entry, toggling every 4 cycles, back to 1 after green;
  - with the macro undefined, Beep stays 1.

Source files
------------

// File: rtl/lights_phase_scheduler.sv
// Round-robin phase scheduler for a three-approach intersection plus pedestrian crossing.
// Optional pedestrian buzzer toggling is compiled in when PED_BEEP_EN is defined.
module lights_phase_scheduler #(
    parameter int unsigned ClockPeriod_ns = 20,
    parameter int unsigned TickCycles     = 50_000_000,
    parameter int unsigned Green_s        = 20,
    parameter int unsigned Yellow_s       = 3,
    parameter int unsigned AllRed_s       = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Req,
    output logic [3:0] Grant,
    output logic       Yellow,
    output logic       AllRed,
    output logic [7:0] SecLeft,
    output logic       Busy,
    output logic       Beep
);

    localparam int unsigned PRESC_W = (TickCycles > 1) ? $clog2(TickCycles) : 1;
    localparam int unsigned SEC_W   = 8;
    localparam logic [SEC_W-1:0] GREEN_LD  = SEC_W'(Green_s);
    localparam logic [SEC_W-1:0] YELLOW_LD = SEC_W'(Yellow_s);
    localparam logic [SEC_W-1:0] CLEAR_LD  = SEC_W'(AllRed_s);

    // Reject parameter sets the timing logic cannot represent.
    if (ClockPeriod_ns == 0 || TickCycles == 0 ||
        Green_s < 1 || Green_s > 255 || Yellow_s < 1 || Yellow_s > 255 ||
        AllRed_s < 1 || AllRed_s > 255) begin : g_bad_params
        $error("lights_phase_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [3:0]         pending_q, pending_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         grant_q, grant_d;
    logic               yellow_q, yellow_d;
    logic               all_red_q, all_red_d;
    logic               busy_q, busy_d;

    logic               tick;
    logic               expire;
    logic               win_found;
    logic [1:0]         win_idx;
    logic [3:0]         req_keep;
    logic               enter_green;

    assign tick   = (presc_q == PRESC_W'(TickCycles - 1));
    assign expire = tick && (sec_q == SEC_W'(1));

    // Round-robin search starting one past the last granted index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && pending_q[2'(ptr_q + 2'(k))]) begin
                win_found = 1'b1;
                win_idx   = 2'(ptr_q + 2'(k));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sec_d       = sec_q;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        enter_green = 1'b0;

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                sec_d   = '0;
                if (win_found) begin
                    enter_green = 1'b1;
                end
            end
            S_GREEN: begin
                if (expire) begin
                    if ((pending_q & ~(4'b0001 << ptr_q)) != 4'b0000) begin
                        state_d = S_YELLOW;
                        sec_d   = YELLOW_LD;
                    end else begin
                        sec_d   = GREEN_LD;
                    end
                end else if (tick) begin
                    sec_d = sec_q - 1'b1;
                end
            end
            S_YELLOW: begin
                if (expire) begin
                    state_d = S_CLEAR;
                    sec_d   = CLEAR_LD;
                end else if (tick) begin
                    sec_d = sec_q - 1'b1;
                end
            end
            S_CLEAR: begin
                if (expire) begin
                    if (win_found) begin
                        enter_green = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        sec_d   = '0;
                    end
                end else if (tick) begin
                    sec_d = sec_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_green) begin
            state_d = S_GREEN;
            ptr_d   = win_idx;
            sec_d   = GREEN_LD;
            presc_d = '0;
        end

        // The requester currently holding the crossing cannot re-queue itself.
        req_keep = Req;
        if (state_q == S_GREEN || state_q == S_YELLOW) begin
            req_keep[ptr_q] = 1'b0;
        end
        pending_d = pending_q | req_keep;
        if (enter_green) begin
            pending_d[win_idx] = 1'b0;
        end

        grant_d   = (state_d == S_GREEN || state_d == S_YELLOW) ? (4'b0001 << ptr_d) : 4'b0000;
        yellow_d  = (state_d == S_YELLOW);
        all_red_d = (state_d == S_IDLE || state_d == S_CLEAR);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd3;
            pending_q <= '0;
            sec_q     <= '0;
            presc_q   <= '0;
            grant_q   <= '0;
            yellow_q  <= 1'b0;
            all_red_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            grant_q   <= grant_d;
            yellow_q  <= yellow_d;
            all_red_q <= all_red_d;
            busy_q    <= busy_d;
        end
    end

`ifdef PED_BEEP_EN
    logic beep_q, beep_d;

    // Buzzer runs only while the pedestrian holds green, starting low on entry.
    always_comb begin
        beep_d = 1'b1;
        if (state_d == S_GREEN && ptr_d == 2'd3) begin
            if (state_q != S_GREEN) begin
                beep_d = 1'b0;
            end else if (tick) begin
                beep_d = ~beep_q;
            end else begin
                beep_d = beep_q;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            beep_q <= 1'b1;
        end else begin
            beep_q <= beep_d;
        end
    end

    assign Beep = beep_q;
`else
    assign Beep = 1'b1;
`endif

    assign Grant   = grant_q;
    assign Yellow  = yellow_q;
    assign AllRed  = all_red_q;
    assign SecLeft = sec_q;
    assign Busy    = busy_q;

endmodule
